// File: rtl/ctrl_seq_pkg.sv
// Shared types for the multicycle control sequencer.
// Phase encodings are visible on the phase output.
package ctrl_seq_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALTED = 3'd5
  } phase_t;

endpackage

// File: rtl/seq_step_counter.sv
// Small up-counter with clear, hold and increment.
// Clear wins over hold; hold wins over increment.
module seq_step_counter #(
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hold,
  input  logic              inc,
  output logic [STEP_W-1:0] count
);

  logic [STEP_W-1:0] count_q;
  logic [STEP_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold && inc) begin
      count_d = count_q + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Multicycle control sequencer: FETCH, DECODE, variable EXEC, WB,
// with fetch timeout, stall, halt/resume and a retired counter.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int MAX_EXEC   = 8,
  parameter int LEN_W      = $clog2(MAX_EXEC + 1),
  parameter int STEP_W     = (MAX_EXEC > 1) ? $clog2(MAX_EXEC) : 1,
  parameter int TIMEOUT    = 15,
  parameter bit CONTINUOUS = 1'b0,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [LEN_W-1:0]   exec_len,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               resume,
  output logic [PHASE_W-1:0] phase,
  output logic [STEP_W-1:0]  step,
  output logic               mem_req,
  output logic               ir_load,
  output logic               exec_en,
  output logic               wb_en,
  output logic               busy,
  output logic [COUNT_W-1:0] instr_count,
  output logic               err_timeout,
  output logic               err_illegal
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_EXEC);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  phase_t             phase_q, phase_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               err_to_q, err_to_d;
  logic               err_il_q, err_il_d;

  logic               step_clr, step_inc;
  logic               wait_clr, wait_inc;
  logic [STEP_W-1:0]  step_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               step_last;

  seq_step_counter #(.STEP_W(STEP_W)) u_step (
    .clk   (clk),
    .reset (reset),
    .clear (step_clr),
    .hold  (stall),
    .inc   (step_inc),
    .count (step_q)
  );

  seq_step_counter #(.STEP_W(WAIT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .clear (wait_clr),
    .hold  (1'b0),
    .inc   (wait_inc),
    .count (wait_q)
  );

  assign step_last = (LEN_W'(step_q) + LEN_W'(1)) == len_q;

  always_comb begin
    phase_d  = phase_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_to_d = err_to_q;
    err_il_d = err_il_q;
    step_clr = 1'b0;
    step_inc = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;
    unique case (phase_q)
      IDLE: begin
        if (halt_req) begin
          phase_d = HALTED;
        end else if (start) begin
          phase_d  = FETCH;
          wait_clr = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          phase_d = DECODE;
        end else if (wait_q == WAIT_MAX) begin
          phase_d  = HALTED;
          err_to_d = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      DECODE: begin
        if (exec_len > MAX_LEN) begin
          phase_d  = HALTED;
          err_il_d = 1'b1;
        end else if (exec_len == '0) begin
          phase_d = WB;
        end else begin
          len_d    = exec_len;
          step_clr = 1'b1;
          phase_d  = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (step_last) begin
            step_clr = 1'b1;
            phase_d  = WB;
          end else begin
            step_inc = 1'b1;
          end
        end
      end
      WB: begin
        cnt_d = cnt_q + COUNT_W'(1);
        if (halt_req) begin
          phase_d = HALTED;
        end else if (CONTINUOUS) begin
          phase_d  = FETCH;
          wait_clr = 1'b1;
        end else begin
          phase_d = IDLE;
        end
      end
      HALTED: begin
        if (resume) begin
          phase_d  = IDLE;
          err_to_d = 1'b0;
          err_il_d = 1'b0;
        end
      end
      default: phase_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_to_q <= err_to_d;
      err_il_q <= err_il_d;
    end
  end

  assign phase       = phase_q;
  assign step        = step_q;
  assign mem_req     = (phase_q == FETCH);
  assign ir_load     = (phase_q == FETCH) & mem_ready;
  assign exec_en     = (phase_q == EXEC);
  assign wb_en       = (phase_q == WB);
  assign busy        = (phase_q != IDLE) && (phase_q != HALTED);
  assign instr_count = cnt_q;
  assign err_timeout = err_to_q;
  assign err_illegal = err_il_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a one-shot and a continuous instance,
// each checked every cycle against a rule-level model.
module tb_ctrl_sequencer;

  localparam int MAX_EXEC = 8;
  localparam int TIMEOUT  = 15;
  localparam int LEN_W    = 4;
  localparam int STEP_W   = 3;

  localparam int P_IDLE = 0, P_FETCH = 1, P_DEC = 2;
  localparam int P_EXEC = 3, P_WB = 4, P_HALT = 5;

  typedef struct {
    int ph; int step; int len; int wt; int cnt; int et; int ei;
  } mst_t;

  logic clk = 1'b0;
  logic reset, start, mem_ready, stall, halt_req, resume;
  logic [LEN_W-1:0] exec_len;
  logic en_a, en_b;
  logic rst_a, rst_b;
  logic chk_on = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  assign rst_a = reset | ~en_a;
  assign rst_b = reset | ~en_b;

  logic [2:0] ph_a, ph_b;
  logic [STEP_W-1:0] st_a, st_b;
  logic mr_a, il_a, ex_a, wb_a, bz_a, et_a, ei_a;
  logic mr_b, il_b, ex_b, wb_b, bz_b, et_b, ei_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b;

  ctrl_sequencer #(.CONTINUOUS(1'b0), .COUNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .start(start), .mem_ready(mem_ready),
    .exec_len(exec_len), .stall(stall), .halt_req(halt_req),
    .resume(resume), .phase(ph_a), .step(st_a), .mem_req(mr_a),
    .ir_load(il_a), .exec_en(ex_a), .wb_en(wb_a), .busy(bz_a),
    .instr_count(cnt_a), .err_timeout(et_a), .err_illegal(ei_a)
  );

  ctrl_sequencer #(.CONTINUOUS(1'b1), .COUNT_W(2)) dut_b (
    .clk(clk), .reset(rst_b), .start(start), .mem_ready(mem_ready),
    .exec_len(exec_len), .stall(stall), .halt_req(halt_req),
    .resume(resume), .phase(ph_b), .step(st_b), .mem_req(mr_b),
    .ir_load(il_b), .exec_en(ex_b), .wb_en(wb_b), .busy(bz_b),
    .instr_count(cnt_b), .err_timeout(et_b), .err_illegal(ei_b)
  );

  always #5 clk = ~clk;

  function automatic mst_t mnext(mst_t s, logic rst, bit cont, int cmod);
    mst_t n = s;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    case (s.ph)
      P_IDLE:
        if (halt_req) n.ph = P_HALT;
        else if (start) begin n.ph = P_FETCH; n.wt = 0; end
      P_FETCH:
        if (mem_ready) n.ph = P_DEC;
        else if (s.wt >= TIMEOUT) begin n.ph = P_HALT; n.et = 1; end
        else n.wt = s.wt + 1;
      P_DEC:
        if (int'(exec_len) > MAX_EXEC) begin n.ph = P_HALT; n.ei = 1; end
        else if (exec_len == 0) n.ph = P_WB;
        else begin n.len = int'(exec_len); n.step = 0; n.ph = P_EXEC; end
      P_EXEC:
        if (!stall) begin
          if (s.step + 1 == s.len) begin n.step = 0; n.ph = P_WB; end
          else n.step = s.step + 1;
        end
      P_WB: begin
        n.cnt = (s.cnt + 1) % cmod;
        if (halt_req) n.ph = P_HALT;
        else if (cont) begin n.ph = P_FETCH; n.wt = 0; end
        else n.ph = P_IDLE;
      end
      P_HALT:
        if (resume) begin n.ph = P_IDLE; n.et = 0; n.ei = 0; end
      default: n.ph = P_IDLE;
    endcase
    return n;
  endfunction

  mst_t ma = '{0, 0, 0, 0, 0, 0, 0};
  mst_t mb = '{0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk) begin
    ma <= mnext(ma, rst_a, 1'b0, 65536);
    mb <= mnext(mb, rst_b, 1'b1, 4);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(string t, mst_t m, logic [2:0] ph,
                         logic [STEP_W-1:0] st, logic mr, logic il,
                         logic ex, logic wb, logic bz, logic [15:0] cn,
                         logic et, logic ei);
    chk({t, ".phase"}, 32'(ph), 32'(m.ph));
    chk({t, ".step"}, 32'(st), 32'(m.step));
    chk({t, ".mem_req"}, 32'(mr), 32'(m.ph == P_FETCH));
    chk({t, ".ir_load"}, 32'(il), 32'(m.ph == P_FETCH && mem_ready));
    chk({t, ".exec_en"}, 32'(ex), 32'(m.ph == P_EXEC));
    chk({t, ".wb_en"}, 32'(wb), 32'(m.ph == P_WB));
    chk({t, ".busy"}, 32'(bz), 32'(m.ph != P_IDLE && m.ph != P_HALT));
    chk({t, ".count"}, 32'(cn), 32'(m.cnt));
    chk({t, ".err_to"}, 32'(et), 32'(m.et));
    chk({t, ".err_il"}, 32'(ei), 32'(m.ei));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_dut("A", ma, ph_a, st_a, mr_a, il_a, ex_a, wb_a, bz_a,
              cnt_a, et_a, ei_a);
      cmp_dut("B", mb, ph_b, st_b, mr_b, il_b, ex_b, wb_b, bz_b,
              16'(cnt_b), et_b, ei_b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  int t1_ph[7] = '{1, 2, 3, 3, 3, 4, 0};
  int t1_st[7] = '{0, 0, 0, 1, 2, 0, 0};
  int t2_st[4] = '{0, 0, 0, 1};

  initial begin
    reset = 1'b1; start = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    halt_req = 1'b0; resume = 1'b0; exec_len = '0;
    en_a = 1'b1; en_b = 1'b1;
    cyc(); cyc();
    chk_on = 1'b1;
    chk("rst_phase", 32'(ph_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_step", 32'(st_a), 0);
    chk("rst_strobes", 32'({mr_a, il_a, ex_a, wb_a, bz_a}), 0);
    chk("rst_errs", 32'({et_a, ei_a}), 0);
    reset = 1'b0; en_b = 1'b0;

    // basic sequence, exec_len=3
    start = 1'b1; mem_ready = 1'b1; exec_len = 4'd3; #1;
    chk("t1_idle", 32'(ph_a), P_IDLE);
    chk("t1_idle_ir", 32'(il_a), 0);
    for (int i = 0; i < 7; i++) begin
      cyc(); start = 1'b0; #1;
      chk("t1_phase", 32'(ph_a), 32'(t1_ph[i]));
      chk("t1_step", 32'(st_a), 32'(t1_st[i]));
      chk("t1_irload", 32'(il_a), 32'(i == 0));
      chk("t1_wb", 32'(wb_a), 32'(i == 5));
    end
    chk("t1_count", 32'(cnt_a), 1);

    // wait states and stall
    start = 1'b1; mem_ready = 1'b0; exec_len = 4'd2;
    cyc(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4); #1;
      chk("t2_fetch", 32'(ph_a), P_FETCH);
      chk("t2_irload", 32'(il_a), 32'(i == 4));
      cyc();
    end
    mem_ready = 1'b0; stall = 1'b1; #1;
    chk("t2_decode", 32'(ph_a), P_DEC);
    for (int i = 0; i < 4; i++) begin
      cyc(); stall = (i < 2); #1;
      chk("t2_exec", 32'(ph_a), P_EXEC);
      chk("t2_step", 32'(st_a), 32'(t2_st[i]));
    end
    cyc(); stall = 1'b0; #1;
    chk("t2_wb", 32'(ph_a), P_WB);
    cyc(); #1;
    chk("t2_idle", 32'(ph_a), P_IDLE);
    chk("t2_count", 32'(cnt_a), 2);

    // fetch timeout
    start = 1'b1; mem_ready = 1'b0;
    cyc(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk("t3_fetch", 32'(ph_a), P_FETCH);
      cyc();
    end
    #1;
    chk("t3_halted", 32'(ph_a), P_HALT);
    chk("t3_err_to", 32'(et_a), 1);
    chk("t3_busy", 32'(bz_a), 0);
    start = 1'b1;
    cyc(); #1;
    chk("t3_start_ign", 32'(ph_a), P_HALT);
    chk("t3_err_sticky", 32'(et_a), 1);
    start = 1'b0; resume = 1'b1;
    cyc(); resume = 1'b0; #1;
    chk("t3_resume", 32'(ph_a), P_IDLE);
    chk("t3_err_clr", 32'(et_a), 0);

    // ready on the last allowed fetch cycle, then zero length
    start = 1'b1;
    cyc(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i == 15);
      #1 chk("t3b_fetch", 32'(ph_a), P_FETCH);
      cyc();
    end
    mem_ready = 1'b0; exec_len = 4'd0; #1;
    chk("t3b_decode", 32'(ph_a), P_DEC);
    chk("t3b_no_err", 32'(et_a), 0);
    cyc(); #1;
    chk("t4_zero_wb", 32'(ph_a), P_WB);
    chk("t4_zero_wben", 32'(wb_a), 1);
    cyc(); #1;
    chk("t4_zero_idle", 32'(ph_a), P_IDLE);
    chk("t4_zero_count", 32'(cnt_a), 3);

    // illegal length
    start = 1'b1; mem_ready = 1'b1; exec_len = 4'd9;
    cyc(); start = 1'b0;
    cyc(); cyc(); #1;
    chk("t4_ill_halt", 32'(ph_a), P_HALT);
    chk("t4_ill_err", 32'(ei_a), 1);
    chk("t4_ill_to", 32'(et_a), 0);
    resume = 1'b1;
    cyc(); resume = 1'b0; #1;
    chk("t4_ill_resume", 32'(ph_a), P_IDLE);
    chk("t4_ill_clr", 32'(ei_a), 0);

    // halt_req beats start in IDLE
    halt_req = 1'b1; start = 1'b1;
    cyc(); halt_req = 1'b0; start = 1'b0; #1;
    chk("t5_halt_prio", 32'(ph_a), P_HALT);
    resume = 1'b1;
    cyc(); resume = 1'b0; #1;
    chk("t5_resume", 32'(ph_a), P_IDLE);

    // continuous instance: wrap of a 2-bit counter
    en_a = 1'b0; en_b = 1'b1;
    start = 1'b1; mem_ready = 1'b1; exec_len = 4'd0; #1;
    chk("t6_idle", 32'(ph_b), P_IDLE);
    cyc(); start = 1'b0; #1;
    for (int k = 0; k < 4; k++) begin
      chk("t6_fetch", 32'(ph_b), P_FETCH);
      cyc(); #1 chk("t6_decode", 32'(ph_b), P_DEC);
      cyc(); #1 chk("t6_wb", 32'(ph_b), P_WB);
      cyc(); #1 chk("t6_refetch", 32'(ph_b), P_FETCH);
      chk("t6_count", 32'(cnt_b), 32'((k + 1) % 4));
    end

    // halt held from EXEC to WB: completes then halts
    exec_len = 4'd2;
    cyc(); #1 chk("t6h_decode", 32'(ph_b), P_DEC);
    cyc(); halt_req = 1'b1; #1;
    chk("t6h_exec0", 32'(ph_b), P_EXEC);
    cyc(); #1;
    chk("t6h_exec1", 32'(ph_b), P_EXEC);
    chk("t6h_step1", 32'(st_b), 1);
    cyc(); #1 chk("t6h_wb", 32'(ph_b), P_WB);
    cyc(); #1;
    chk("t6h_halted", 32'(ph_b), P_HALT);
    chk("t6h_count", 32'(cnt_b), 1);
    halt_req = 1'b0;

    // reset in the middle of EXEC
    en_b = 1'b0; en_a = 1'b1;
    start = 1'b1; mem_ready = 1'b1; exec_len = 4'd4;
    cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    reset = 1'b1; #1;
    chk("t7_pre_step", 32'(st_a), 1);
    chk("t7_pre_phase", 32'(ph_a), P_EXEC);
    cyc(); reset = 1'b0; #1;
    chk("t7_phase", 32'(ph_a), P_IDLE);
    chk("t7_step", 32'(st_a), 0);
    chk("t7_strobes", 32'({mr_a, il_a, ex_a, wb_a, bz_a}), 0);

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
